// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage forwarding and operand selection; 1-cycle D->E latency.
// Stall (EnE=0) holds all state while the forwarding muxes stay live; FlushE loads a bubble and beats EnE.
module id_ex_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EnE,
    input  logic               FlushE,
    input  logic [WIDTH-1:0]   RD1D,
    input  logic [WIDTH-1:0]   RD2D,
    input  logic [WIDTH-1:0]   SignImmD,
    input  logic [REGBITS-1:0] RsD,
    input  logic [REGBITS-1:0] RtD,
    input  logic [REGBITS-1:0] RdD,
    input  logic [3:0]         ALUControlD,
    input  logic               ALUSrcD,
    input  logic               RegDstD,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               MemWriteD,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [WIDTH-1:0]   ResultW,
    input  logic [WIDTH-1:0]   ALUOutM,
    output logic [WIDTH-1:0]   SrcAE,
    output logic [WIDTH-1:0]   SrcBE,
    output logic [WIDTH-1:0]   WriteDataE,
    output logic [3:0]         ALUControlE,
    output logic [REGBITS-1:0] WriteRegE,
    output logic [REGBITS-1:0] RsE,
    output logic [REGBITS-1:0] RtE,
    output logic               RegWriteE,
    output logic               MemtoRegE,
    output logic               MemWriteE
);

    typedef struct packed {
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [WIDTH-1:0]   imm;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
        logic [3:0]         alu_ctl;
        logic               alu_src;
        logic               reg_dst;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_write;
    } stage_t;

    stage_t issue_dat;
    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        issue_dat            = '0;
        issue_dat.rd1        = RD1D;
        issue_dat.rd2        = RD2D;
        issue_dat.imm        = SignImmD;
        issue_dat.rs         = RsD;
        issue_dat.rt         = RtD;
        issue_dat.rd         = RdD;
        issue_dat.alu_ctl    = ALUControlD;
        issue_dat.alu_src    = ALUSrcD;
        issue_dat.reg_dst    = RegDstD;
        issue_dat.reg_write  = RegWriteD;
        issue_dat.mem_to_reg = MemtoRegD;
        issue_dat.mem_write  = MemWriteD;
    end

    // A bubble is the all-zero stage word, so flush and reset share one encoding.
    always_comb begin
        stage_d = stage_q;
        if (FlushE) begin
            stage_d = '0;
        end else if (EnE) begin
            stage_d = issue_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Code 2'b11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel, input logic [WIDTH-1:0] reg_val);
        case (sel)
            2'b01:   fwd_sel = ResultW;
            2'b10:   fwd_sel = ALUOutM;
            default: fwd_sel = reg_val;
        endcase
    endfunction

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    always_comb begin
        fwd_a = fwd_sel(ForwardAE, stage_q.rd1);
        fwd_b = fwd_sel(ForwardBE, stage_q.rd2);
    end

    assign SrcAE       = fwd_a;
    assign SrcBE       = stage_q.alu_src ? stage_q.imm : fwd_b;
    assign WriteDataE  = fwd_b;
    assign ALUControlE = stage_q.alu_ctl;
    assign WriteRegE   = stage_q.reg_dst ? stage_q.rd : stage_q.rt;
    assign RsE         = stage_q.rs;
    assign RtE         = stage_q.rt;
    assign RegWriteE   = stage_q.reg_write;
    assign MemtoRegE   = stage_q.mem_to_reg;
    assign MemWriteE   = stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps followed by randomized traffic against an
// instruction-level model of what the execute stage should present.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EnE, FlushE;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD;
    logic [3:0]  ALUControlD;
    logic        ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW, ALUOutM;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic [3:0]  ALUControlE;
    logic [4:0]  WriteRegE, RsE, RtE;
    logic        RegWriteE, MemtoRegE, MemWriteE;

    int checks = 0;
    int errors = 0;

    // Instruction currently sitting in E, as the model believes it.
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [3:0]  m_alu;
    logic        m_alusrc, m_regdst, m_rw, m_mtr, m_mw;

    id_ex_stage #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .EnE(EnE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .ALUOutM(ALUOutM),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
        .ALUControlE(ALUControlE), .WriteRegE(WriteRegE),
        .RsE(RsE), .RtE(RtE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_alu = 0;
        m_alusrc = 0; m_regdst = 0; m_rw = 0; m_mtr = 0; m_mw = 0;
    endtask

    // The instruction presented in D moves to E on a load edge; flush empties E.
    task automatic tick();
        if (!rst_n || FlushE) begin
            model_clear();
        end else if (EnE) begin
            m_rd1 = RD1D; m_rd2 = RD2D; m_imm = SignImmD;
            m_rs = RsD; m_rt = RtD; m_rd = RdD; m_alu = ALUControlD;
            m_alusrc = ALUSrcD; m_regdst = RegDstD; m_rw = RegWriteD;
            m_mtr = MemtoRegD; m_mw = MemWriteD;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] operand(input logic [1:0] code, input logic [31:0] reg_val);
        if (code == 2'd1) return ResultW;
        if (code == 2'd2) return ALUOutM;
        return reg_val;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] b;
        b = operand(ForwardBE, m_rd2);
        chk({tag, ".SrcAE"}, SrcAE, operand(ForwardAE, m_rd1));
        chk({tag, ".SrcBE"}, SrcBE, m_alusrc ? m_imm : b);
        chk({tag, ".WriteDataE"}, WriteDataE, b);
        chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(m_alu));
        chk({tag, ".WriteRegE"}, 32'(WriteRegE), 32'(m_regdst ? m_rd : m_rt));
        chk({tag, ".RsE"}, 32'(RsE), 32'(m_rs));
        chk({tag, ".RtE"}, 32'(RtE), 32'(m_rt));
        chk({tag, ".ctl"}, {29'd0, RegWriteE, MemtoRegE, MemWriteE}, {29'd0, m_rw, m_mtr, m_mw});
    endtask

    task automatic rand_d();
        RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
        RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
        ALUControlD = 4'($urandom_range(0, 13));
        ALUSrcD = 1'($urandom); RegDstD = 1'($urandom); RegWriteD = 1'($urandom);
        MemtoRegD = 1'($urandom); MemWriteD = 1'($urandom);
    endtask

    task automatic zero_d();
        RD1D = 0; RD2D = 0; SignImmD = 0; RsD = 0; RtD = 0; RdD = 0; ALUControlD = 0;
        ALUSrcD = 0; RegDstD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0;
    endtask

    initial begin
        rst_n = 1'b1; EnE = 1'b1; FlushE = 1'b0;
        ForwardAE = 0; ForwardBE = 0; ResultW = $urandom; ALUOutM = $urandom;
        rand_d();
        model_clear();

        // Reset without any clock edge (first posedge is at t=5).
        #2 rst_n = 1'b0;
        #1;
        chk("rst.ALUControlE", 32'(ALUControlE), 0);
        chk("rst.RegWriteE", 32'(RegWriteE), 0);
        chk("rst.MemWriteE", 32'(MemWriteE), 0);
        chk("rst.SrcAE", SrcAE, 0);
        chk("rst.SrcBE", SrcBE, 0);
        check_all("rst");
        tick();
        rst_n = 1'b1;

        // Pass-through.
        zero_d();
        RD1D = 5; RD2D = 7; ALUControlD = 1; RegDstD = 1; RdD = 9; RegWriteD = 1;
        tick();
        chk("pass.SrcAE", SrcAE, 5);
        chk("pass.SrcBE", SrcBE, 7);
        chk("pass.ALUControlE", 32'(ALUControlE), 1);
        chk("pass.WriteRegE", 32'(WriteRegE), 9);
        chk("pass.RegWriteE", 32'(RegWriteE), 1);

        // Forwarding from MEM/WB, and code 11 falling back to the register.
        ALUOutM = 32'h100; ResultW = 32'h200; ForwardAE = 2'b10; ForwardBE = 2'b01;
        #1;
        chk("fwd.SrcAE_mem", SrcAE, 32'h100);
        chk("fwd.SrcBE_wb", SrcBE, 32'h200);
        ForwardAE = 2'b11;
        #1;
        chk("fwd.SrcAE_11", SrcAE, 5);
        check_all("fwd");

        // Immediate operand versus store data.
        ForwardAE = 0; ForwardBE = 0;
        ALUSrcD = 1; SignImmD = 32'hFFFF_FFFC; RD2D = 32'h1234;
        tick();
        chk("imm.SrcBE", SrcBE, 32'hFFFF_FFFC);
        chk("imm.WriteDataE", WriteDataE, 32'h1234);
        ForwardBE = 2'b10; ALUOutM = 32'hABCD;
        #1;
        chk("imm.WriteDataE_fwd", WriteDataE, 32'hABCD);
        chk("imm.SrcBE_hold", SrcBE, 32'hFFFF_FFFC);
        ForwardBE = 0;

        // Stall for three edges, then flush while still stalled.
        ALUControlD = 4; RegWriteD = 1; MemWriteD = 1;
        tick();
        chk("stall.load", 32'(ALUControlE), 4);
        EnE = 0;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            tick();
            chk("stall.hold", 32'(ALUControlE), 4);
            check_all("stall");
        end
        FlushE = 1;
        tick();
        chk("flush.ALUControlE", 32'(ALUControlE), 0);
        chk("flush.RegWriteE", 32'(RegWriteE), 0);
        chk("flush.MemWriteE", 32'(MemWriteE), 0);
        FlushE = 0;

        // Asynchronous reset between edges, then release under stall.
        EnE = 1; zero_d(); RegWriteD = 1; ALUControlD = 3;
        tick();
        chk("arst.pre", 32'(RegWriteE), 1);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst.RegWriteE", 32'(RegWriteE), 0);
        EnE = 0; rst_n = 1'b1;
        tick();
        tick();
        chk("arst.held_zero", 32'(ALUControlE), 0);
        check_all("arst.hold");
        EnE = 1; ALUControlD = 7;
        tick();
        chk("arst.reload", 32'(ALUControlE), 7);

        // Randomized traffic, with forwarding changes between edges and occasional async reset.
        for (int n = 0; n < 300; n++) begin
            rand_d();
            EnE = ($urandom_range(0, 3) != 0);
            FlushE = ($urandom_range(0, 7) == 0);
            tick();
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ResultW = $urandom; ALUOutM = $urandom;
            #1;
            check_all("rnd");
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                check_all("rnd.arst");
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
